// File: rtl/crossbar_arbiter_if.sv
// crossbar_arbiter_if: handshake bundle between the two ingress ports, the two
// egress ports and the crossbar arbiter. The slave modport is the arbiter's
// view. The master modport is the view of whatever drives the streams.
interface crossbar_arbiter_if;
  logic       p0_valid;
  logic       p0_last;
  logic       p0_ready;
  logic       p1_valid;
  logic       p1_last;
  logic       p1_bcast;
  logic       p1_ready;
  logic       out0_ready;
  logic       out1_ready;
  logic       out0_valid;
  logic       out1_valid;
  logic [1:0] control_crossbar;
  logic       overrun_err;
  logic       timeout_err;

  modport slave (
    input  p0_valid, p0_last, p1_valid, p1_last, p1_bcast,
    input  out0_ready, out1_ready,
    output p0_ready, p1_ready, out0_valid, out1_valid,
    output control_crossbar, overrun_err, timeout_err
  );

  modport master (
    output p0_valid, p0_last, p1_valid, p1_last, p1_bcast,
    output out0_ready, out1_ready,
    input  p0_ready, p1_ready, out0_valid, out1_valid,
    input  control_crossbar, overrun_err, timeout_err
  );
endinterface

// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter: round-robin packet arbiter for the two-port lane crossbar.
// A grant is held for a whole packet. It is released on the last beat, or it
// is forced off after MAX_PKT_BEATS beats, in which case overrun_err pulses.
// Optional stall watchdog: define CROSSBAR_ARB_TIMEOUT_EN to enable it. The
// watchdog drops a grant after TIMEOUT_CYCLES cycles without a beat and pulses
// timeout_err. Without the macro, timeout_err is tied low.
module crossbar_arbiter #(
  parameter int unsigned MAX_PKT_BEATS  = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  crossbar_arbiter_if.slave bus
);

  // State encoding doubles as the crossbar select value.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G_P0 = 2'b01,
    G_P1 = 2'b10,
    G_BC = 2'b11
  } state_t;

  // Beat index (0-based) at which a packet without last is cut off.
  localparam logic [15:0] LAST_BEAT_IDX = 16'(MAX_PKT_BEATS - 1);

  if (MAX_PKT_BEATS < 2 || MAX_PKT_BEATS > 65535) begin : g_bad_max_beats
    $error("crossbar_arbiter: MAX_PKT_BEATS must be within 2..65535");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("crossbar_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  state_t      state_q, state_d;
  logic        rr_q, rr_d;              // 1: port 1 preferred on a tie
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;

  logic p0_ready, p1_ready, out0_valid, out1_valid;
  logic both_ready, beat, beat_last, drop_grant;

`ifdef CROSSBAR_ARB_TIMEOUT_EN
  localparam logic [15:0] LAST_STALL_IDX = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] stall_cnt_q, stall_cnt_d;
`endif

  // Per-beat handshakes: pure function of the grant state and live ready/valid.
  always_comb begin
    p0_ready   = 1'b0;
    p1_ready   = 1'b0;
    out0_valid = 1'b0;
    out1_valid = 1'b0;
    both_ready = bus.out0_ready & bus.out1_ready;
    case (state_q)
      G_P0: begin
        out1_valid = bus.p0_valid;
        p0_ready   = bus.out1_ready;
      end
      G_P1: begin
        out0_valid = bus.p1_valid;
        p1_ready   = bus.out0_ready;
      end
      G_BC: begin
        // A broadcast beat moves only when both egress sides can take it.
        p1_ready   = both_ready;
        out0_valid = bus.p1_valid & both_ready;
        out1_valid = bus.p1_valid & both_ready;
      end
      default: ;
    endcase
  end

  // Readies are zero outside the granted port, so OR-ing both ports is safe.
  assign beat      = (p0_ready & bus.p0_valid) | (p1_ready & bus.p1_valid);
  assign beat_last = (state_q == G_P0) ? bus.p0_last : bus.p1_last;

  // Arbitration, beat/stall counting and grant release decisions.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;
    drop_grant = 1'b0;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
`endif
    if (state_q == IDLE) begin
      // Counters are held at zero so every grant starts from a clean count.
      beat_cnt_d = '0;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
      stall_cnt_d = '0;
`endif
      if (bus.p0_valid && (!bus.p1_valid || !rr_q)) begin
        state_d = G_P0;
      end else if (bus.p1_valid) begin
        state_d = bus.p1_bcast ? G_BC : G_P1;
      end
    end else begin
      if (beat) begin
        beat_cnt_d = beat_cnt_q + 16'd1;
        if (beat_last) begin
          drop_grant = 1'b1;
        end else if (beat_cnt_q == LAST_BEAT_IDX) begin
          drop_grant = 1'b1;
          overrun_d  = 1'b1;
        end
      end
`ifdef CROSSBAR_ARB_TIMEOUT_EN
      if (beat) begin
        stall_cnt_d = '0;
      end else if (stall_cnt_q == LAST_STALL_IDX) begin
        drop_grant = 1'b1;
        timeout_d  = 1'b1;
      end else begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
`endif
      if (drop_grant) begin
        state_d = IDLE;
        // Whoever just finished yields the next tie to the other port.
        rr_d    = (state_q == G_P0);
      end
    end
  end

  // State, pointer, counters and error pulses; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      beat_cnt_q  <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      beat_cnt_q  <= beat_cnt_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign bus.p0_ready         = p0_ready;
  assign bus.p1_ready         = p1_ready;
  assign bus.out0_valid       = out0_valid;
  assign bus.out1_valid       = out1_valid;
  assign bus.control_crossbar = state_q;
  assign bus.overrun_err      = overrun_q;
`ifdef CROSSBAR_ARB_TIMEOUT_EN
  assign bus.timeout_err      = timeout_q;
`else
  assign bus.timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_crossbar_arbiter.sv
// tb_crossbar_arbiter: directed table-driven bench for crossbar_arbiter
// (MAX_PKT_BEATS=4, TIMEOUT_CYCLES=16), plus hand sequences for the
// watchdog/hold behaviour and a mid-packet reset.
// Input vector bits:  {p0_valid,p0_last, p1_valid,p1_last,p1_bcast, out0_ready,out1_ready}
// Output vector bits: {control_crossbar[1:0], p0_ready,p1_ready, out0_valid,out1_valid, overrun_err,timeout_err}
module tb_crossbar_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  crossbar_arbiter_if bus();

  crossbar_arbiter #(
    .MAX_PKT_BEATS (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic [6:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic r, logic [6:0] in, logic [7:0] exp);
    vec_t v;
    v.name  = name;
    v.rst_n = r;
    v.in    = in;
    v.exp   = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] outs();
    return {bus.control_crossbar, bus.p0_ready, bus.p1_ready,
            bus.out0_valid, bus.out1_valid, bus.overrun_err, bus.timeout_err};
  endfunction

  task automatic set_in(logic [6:0] in);
    {bus.p0_valid, bus.p0_last, bus.p1_valid, bus.p1_last, bus.p1_bcast,
     bus.out0_ready, bus.out1_ready} = in;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s value %0h", name, act);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int bad;

    // A: port 0, 3-beat packet, egress always ready.
    add("a_c0_idle",   1'b1, 7'b10_000_11, 8'b00_00_00_00);
    add("a_c1_beat1",  1'b1, 7'b10_000_11, 8'b01_10_01_00);
    add("a_c2_beat2",  1'b1, 7'b10_000_11, 8'b01_10_01_00);
    add("a_c3_last",   1'b1, 7'b11_000_11, 8'b01_10_01_00);
    add("a_c4_idle",   1'b1, 7'b00_000_11, 8'b00_00_00_00);
    // Reset, then both ports with 2-beat packets pending.
    add("b_reset",     1'b0, 7'b00_000_11, 8'b00_00_00_00);
    add("b_c0_both",   1'b1, 7'b10_100_11, 8'b00_00_00_00);
    add("b_c1_p0",     1'b1, 7'b10_100_11, 8'b01_10_01_00);
    add("b_c2_p0last", 1'b1, 7'b11_100_11, 8'b01_10_01_00);
    add("b_c3_gap",    1'b1, 7'b00_100_11, 8'b00_00_00_00);
    add("b_c4_p1",     1'b1, 7'b00_100_11, 8'b10_01_10_00);
    add("b_c5_p1last", 1'b1, 7'b00_110_11, 8'b10_01_10_00);
    add("b_c6_idle",   1'b1, 7'b00_000_11, 8'b00_00_00_00);
    // C: both ports stream 1-beat packets; grants alternate.
    add("c_c0_both",   1'b1, 7'b11_110_11, 8'b00_00_00_00);
    add("c_c1_p0",     1'b1, 7'b11_110_11, 8'b01_10_01_00);
    add("c_c2_gap",    1'b1, 7'b11_110_11, 8'b00_00_00_00);
    add("c_c3_p1bp",   1'b1, 7'b11_110_01, 8'b10_00_10_00);
    add("c_c4_p1",     1'b1, 7'b11_110_11, 8'b10_01_10_00);
    add("c_c5_gap",    1'b1, 7'b11_000_11, 8'b00_00_00_00);
    add("c_c6_p0",     1'b1, 7'b11_000_11, 8'b01_10_01_00);
    add("c_c7_idle",   1'b1, 7'b00_000_11, 8'b00_00_00_00);
    // D: broadcast, one egress side stalled for 2 cycles.
    add("d_c0_req",    1'b1, 7'b00_101_11, 8'b00_00_00_00);
    add("d_c1_o1stall",1'b1, 7'b10_100_10, 8'b11_00_00_00);
    add("d_c2_o0stall",1'b1, 7'b10_100_01, 8'b11_00_00_00);
    add("d_c3_beat1",  1'b1, 7'b10_100_11, 8'b11_01_11_00);
    add("d_c4_last",   1'b1, 7'b00_110_11, 8'b11_01_11_00);
    add("d_c5_idle",   1'b1, 7'b00_000_11, 8'b00_00_00_00);
    // E: port 1 streams without last: overrun at the 4th beat.
    add("e_c0_req",    1'b1, 7'b00_100_11, 8'b00_00_00_00);
    add("e_c1_beat1",  1'b1, 7'b00_100_11, 8'b10_01_10_00);
    add("e_c2_beat2",  1'b1, 7'b00_100_11, 8'b10_01_10_00);
    add("e_c3_beat3",  1'b1, 7'b00_100_11, 8'b10_01_10_00);
    add("e_c4_beat4",  1'b1, 7'b00_100_11, 8'b10_01_10_00);
    add("e_c5_overrun",1'b1, 7'b00_100_11, 8'b00_00_00_10);
    add("e_c6_regrant",1'b1, 7'b00_110_11, 8'b10_01_10_00);
    add("e_c7_idle",   1'b1, 7'b00_000_11, 8'b00_00_00_00);
    // F: 4-beat packet with last on the 4th beat (no overrun), with stalls.
    add("f_c0_req",    1'b1, 7'b10_000_11, 8'b00_00_00_00);
    add("f_c1_beat1",  1'b1, 7'b10_000_11, 8'b01_10_01_00);
    add("f_c2_bp",     1'b1, 7'b10_000_10, 8'b01_00_01_00);
    add("f_c3_novalid",1'b1, 7'b00_000_11, 8'b01_10_00_00);
    add("f_c4_beat2",  1'b1, 7'b10_000_11, 8'b01_10_01_00);
    add("f_c5_beat3",  1'b1, 7'b10_000_11, 8'b01_10_01_00);
    add("f_c6_beat4",  1'b1, 7'b11_000_11, 8'b01_10_01_00);
    add("f_c7_noerr",  1'b1, 7'b00_000_11, 8'b00_00_00_00);

    // Initial reset.
    set_in(7'b00_000_00);
    rst_n = 1'b0;
    tick();
    tick();

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      set_in(vecs[i].in);
      #1;
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      tick();
    end
    rst_n = 1'b1;

    // Watchdog / indefinite hold: port 0 granted, one beat, then valid drops.
    set_in(7'b10_000_11); #1; check("wd_idle", 32'(outs()), 32'h00);          tick();
    set_in(7'b10_000_11); #1; check("wd_beat", 32'(outs()), 32'b01_10_01_00); tick();
    set_in(7'b00_000_11);
`ifdef CROSSBAR_ARB_TIMEOUT_EN
    n = 0;
    while (bus.control_crossbar == 2'b01 && n < 100) begin
      tick();
      n++;
    end
    check("wd_stall_cycles", 32'(n), 32'd16);
    #1;
    check("wd_timeout_pulse", 32'(outs()), 32'b00_00_00_01);
    tick();
    check("wd_pulse_ends", 32'(outs()), 32'h00);
    tick();
`else
    bad = 0;
    repeat (120) begin
      tick();
      if (outs() !== 8'b01_10_00_00) bad++;
    end
    check("hold_120_cycles", 32'(bad), 32'd0);
    set_in(7'b11_000_11); #1; check("hold_last", 32'(outs()), 32'b01_10_01_00); tick();
    set_in(7'b00_000_11); #1; check("hold_idle", 32'(outs()), 32'h00);         tick();
`endif

    // Mid-packet reset on beat 2 of a 5-beat port-1 packet; pointer now favours port 1.
    set_in(7'b00_100_11); #1; check("rst_req",   32'(outs()), 32'h00);         tick();
    set_in(7'b00_100_11); #1; check("rst_beat1", 32'(outs()), 32'b10_01_10_00); tick();
    rst_n = 1'b0;
    set_in(7'b00_100_11); #1; check("rst_beat2", 32'(outs()), 32'b10_01_10_00); tick();
    rst_n = 1'b1;
    set_in(7'b10_100_11); #1; check("rst_dropped", 32'(outs()), 32'h00);        tick();
    set_in(7'b11_100_11); #1; check("rst_p0_wins", 32'(outs()), 32'b01_10_01_00); tick();
    set_in(7'b00_000_11); #1; check("rst_final_idle", 32'(outs()), 32'h00);     tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
